// File: rtl/led_frame_buffer_pkg.sv
// Shared constants, FSM state type and gamma table for the LED matrix pipeline
// (frame buffer, scan PWM and matrix driver stages).
package led_pkg;

  localparam int unsigned ROWS    = 4;
  localparam int unsigned COLS    = 8;
  localparam int unsigned LEVEL_W = 4;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned ROW_W   = COLS * LEVEL_W;

  typedef enum logic {
    FILL    = 1'b0,
    PENDING = 1'b1
  } state_t;

  // Entry n sits at bits [n*4 +: 4]: 0,0,0,0,1,1,1,2,2,3,4,5,6,8,10,15
  localparam logic [16*LEVEL_W-1:0] GAMMA_LUT = 64'hFA86_5432_2111_0000;

endpackage

// File: rtl/led_frame_buffer_if.sv
// Pixel write handshake into the frame buffer back store.
interface led_frame_buffer_if;

  logic                       i_wr_valid;
  logic                       o_wr_ready;
  logic                       i_wr_first;
  logic [led_pkg::LEVEL_W-1:0] i_wr_data;

  modport master (output i_wr_valid, output i_wr_first, output i_wr_data, input o_wr_ready);
  modport slave  (input i_wr_valid, input i_wr_first, input i_wr_data, output o_wr_ready);

endinterface

// File: rtl/led_frame_buffer_gamma_lut.sv
// Fixed 16-entry brightness gamma map, 4-bit level in, 4-bit level out.
module led_gamma_lut
  import led_pkg::*;
(
  input  logic [LEVEL_W-1:0] level_i,
  output logic [LEVEL_W-1:0] level_o
);

  assign level_o = GAMMA_LUT[level_i*LEVEL_W +: LEVEL_W];

endmodule

// File: rtl/led_frame_buffer.sv
// Double-buffered pixel level store feeding the scan PWM stage.
// Build option LED_FRAME_BUFFER_GAMMA_EN routes written pixels through led_gamma_lut.
module led_frame_buffer
  import led_pkg::*;
(
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_frame_tick,
  led_frame_buffer_if.slave    wr,
  output logic [ROW_W-1:0]     o_row0_levels,
  output logic [ROW_W-1:0]     o_row1_levels,
  output logic [ROW_W-1:0]     o_row2_levels,
  output logic [ROW_W-1:0]     o_row3_levels,
  output logic                 o_swap,
  output logic [7:0]           o_frame_count
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ROW_W-1:0]    back_q  [ROWS];
  logic [ROW_W-1:0]    front_q [ROWS];
  logic                swap_q;
  logic [7:0]          count_q;

  logic                xfer;
  logic                swap_now;
  logic [ADDR_W-1:0]   wr_addr;
  logic [LEVEL_W-1:0]  pix;

`ifdef LED_FRAME_BUFFER_GAMMA_EN
  led_gamma_lut u_gamma (
    .level_i (wr.i_wr_data),
    .level_o (pix)
  );
`else
  assign pix = wr.i_wr_data;
`endif

  // A first-flagged pixel always restarts the frame at address 0
  assign xfer    = wr.i_wr_valid && wr.o_wr_ready;
  assign wr_addr = wr.i_wr_first ? '0 : addr_q;
  assign addr_d  = xfer ? wr_addr + 1'b1 : addr_q;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (xfer && wr_addr == '1) state_d = PENDING;
      PENDING: if (i_frame_tick)          state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    wr.o_wr_ready = (state_q == FILL);
    swap_now      = (state_q == PENDING) && i_frame_tick;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      addr_q  <= '0;
      swap_q  <= 1'b0;
      count_q <= '0;
      for (int unsigned r = 0; r < ROWS; r++) begin
        back_q[r]  <= '0;
        front_q[r] <= '0;
      end
    end else begin
      addr_q <= addr_d;
      swap_q <= swap_now;
      if (xfer) begin
        back_q[wr_addr[ADDR_W-1:3]][wr_addr[2:0]*LEVEL_W +: LEVEL_W] <= pix;
      end
      if (swap_now) begin
        count_q <= count_q + 8'd1;
        for (int unsigned r = 0; r < ROWS; r++) begin
          front_q[r] <= back_q[r];
        end
      end
    end
  end

  assign o_row0_levels = front_q[0];
  assign o_row1_levels = front_q[1];
  assign o_row2_levels = front_q[2];
  assign o_row3_levels = front_q[3];
  assign o_swap        = swap_q;
  assign o_frame_count = count_q;

endmodule

// File: tb/tb_led_frame_buffer.sv
// Scoreboard bench for led_frame_buffer: expected front-buffer frames are queued
// when the swapping tick is driven and popped when o_swap is seen.
module tb_led_frame_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic [31:0] row0, row1, row2, row3;
  logic        swap;
  logic [7:0]  fcount;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rows [4];
    logic [7:0]  cnt;
  } exp_t;
  exp_t exp_q [$];

  logic [3:0]  m_back [32];
  logic [31:0] m_front [4];
  int unsigned m_addr;
  logic        m_pending;
  logic [7:0]  m_count;

  led_frame_buffer_if wr_if ();

  led_frame_buffer dut (
    .i_clock       (clk),
    .i_reset_n     (rst_n),
    .i_frame_tick  (tick),
    .wr            (wr_if),
    .o_row0_levels (row0),
    .o_row1_levels (row1),
    .o_row2_levels (row2),
    .o_row3_levels (row3),
    .o_swap        (swap),
    .o_frame_count (fcount)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] model_pix(input logic [3:0] d);
`ifdef LED_FRAME_BUFFER_GAMMA_EN
    case (d)
      4'd4, 4'd5, 4'd6: return 4'd1;
      4'd7, 4'd8:       return 4'd2;
      4'd9:             return 4'd3;
      4'd10:            return 4'd4;
      4'd11:            return 4'd5;
      4'd12:            return 4'd6;
      4'd13:            return 4'd8;
      4'd14:            return 4'd10;
      4'd15:            return 4'd15;
      default:          return 4'd0;
    endcase
`else
    return d;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_back[i] = 4'h0;
    for (int r = 0; r < 4; r++) m_front[r] = 32'h0;
    m_addr    = 0;
    m_pending = 1'b0;
    m_count   = 8'd0;
    exp_q.delete();
  endtask

  task automatic step(input logic v, input logic f, input logic [3:0] d, input logic t);
    logic  exp_swap;
    int unsigned wa;
    exp_t  e;
    wr_if.i_wr_valid = v;
    wr_if.i_wr_first = f;
    wr_if.i_wr_data  = d;
    tick             = t;
    exp_swap         = 1'b0;
    if (!m_pending) begin
      if (v) begin
        wa         = f ? 0 : m_addr;
        m_back[wa] = model_pix(d);
        m_addr     = (wa + 1) % 32;
        if (wa == 31) m_pending = 1'b1;
      end
    end else if (t) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 8; c++)
          m_front[r][c*4 +: 4] = m_back[r*8 + c];
      m_count   = m_count + 8'd1;
      m_pending = 1'b0;
      exp_swap  = 1'b1;
      e.rows    = m_front;
      e.cnt     = m_count;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    checks++;
    if (wr_if.o_wr_ready !== !m_pending) begin
      errors++;
      $display("FAIL ready: got %b want %b", wr_if.o_wr_ready, !m_pending);
    end
    checks++;
    if (swap !== exp_swap) begin
      errors++;
      $display("FAIL swap_pulse: got %b want %b", swap, exp_swap);
    end
    if (swap === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL swap_unexpected: got swap want none queued");
      end else begin
        e = exp_q.pop_front();
        if ({row0, row1, row2, row3} !== {e.rows[0], e.rows[1], e.rows[2], e.rows[3]} ||
            fcount !== e.cnt) begin
          errors++;
          $display("FAIL swap_frame: got %h %h %h %h cnt %0d want %h %h %h %h cnt %0d",
                   row0, row1, row2, row3, fcount, e.rows[0], e.rows[1], e.rows[2], e.rows[3], e.cnt);
        end
      end
    end
    checks++;
    if ({row0, row1, row2, row3} !== {m_front[0], m_front[1], m_front[2], m_front[3]} ||
        fcount !== m_count) begin
      errors++;
      $display("FAIL rows_stable: got %h %h %h %h cnt %0d want %h %h %h %h cnt %0d",
               row0, row1, row2, row3, fcount, m_front[0], m_front[1], m_front[2], m_front[3], m_count);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic check_rows(input string name, input logic [31:0] want);
    checks++;
    if (row0 !== want || row1 !== want || row2 !== want || row3 !== want) begin
      errors++;
      $display("FAIL %s: got %h %h %h %h want %h", name, row0, row1, row2, row3, want);
    end
  endtask

  task automatic send_frame(input logic [3:0] val, input logic first0);
    for (int i = 0; i < 32; i++) step(1'b1, first0 && i == 0, val, 1'b0);
  endtask

  task automatic test_reset();
    wr_if.i_wr_valid = 1'b0;
    wr_if.i_wr_first = 1'b0;
    wr_if.i_wr_data  = 4'h0;
    tick             = 1'b0;
    rst_n            = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_rows("reset_rows", 32'h0);
    checks++;
    if (wr_if.o_wr_ready !== 1'b1 || swap !== 1'b0 || fcount !== 8'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy %b swap %b cnt %0d want 1 0 0", wr_if.o_wr_ready, swap, fcount);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 4'h0, 1'b1);
      step(1'b0, 1'b0, 4'h0, 1'b0);
    end
  endtask

  task automatic test_full_frame();
    logic [4:0] a;
    for (int i = 0; i < 32; i++) begin
      a = 5'(i);
      step(1'b1, i == 0, a[3:0], 1'b0);
    end
    idle(2);
    step(1'b0, 1'b0, 4'h0, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b0);
`ifndef LED_FRAME_BUFFER_GAMMA_EN
    checks++;
    if (row0 !== 32'h7654_3210 || row1 !== 32'hFEDC_BA98 ||
        row2 !== 32'h7654_3210 || row3 !== 32'hFEDC_BA98 || fcount !== 8'd1) begin
      errors++;
      $display("FAIL full_frame_literal: got %h %h %h %h cnt %0d want 76543210 fedcba98 76543210 fedcba98 cnt 1",
               row0, row1, row2, row3, fcount);
    end
`endif
  endtask

  task automatic test_backpressure();
    send_frame(4'h3, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 4'hF, 1'b0);
    step(1'b1, 1'b0, 4'hF, 1'b1);
    send_frame(4'h1, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b1);
`ifndef LED_FRAME_BUFFER_GAMMA_EN
    check_rows("backpressure_ones", 32'h1111_1111);
`endif
  endtask

  task automatic test_restart();
    for (int i = 0; i < 10; i++) step(1'b1, i == 0, 4'h5, 1'b0);
    step(1'b0, 1'b0, 4'h0, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b1);
    send_frame(4'hA, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b1);
`ifndef LED_FRAME_BUFFER_GAMMA_EN
    check_rows("restart_a", 32'hAAAA_AAAA);
`endif
  endtask

  task automatic test_tick_coincident();
    for (int i = 0; i < 31; i++) step(1'b1, i == 0, 4'h6, 1'b0);
    step(1'b1, 1'b0, 4'hC, 1'b1);
    idle(2);
    step(1'b0, 1'b0, 4'h0, 1'b1);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 20; i++) step(1'b1, i == 0, 4'h9, 1'b0);
    wr_if.i_wr_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_rows("async_reset_rows", 32'h0);
    checks++;
    if (wr_if.o_wr_ready !== 1'b1 || fcount !== 8'd0 || swap !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_ctrl: got rdy %b cnt %0d swap %b want 1 0 0", wr_if.o_wr_ready, fcount, swap);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 32; i++) step(1'b1, 1'b0, 4'(i) ^ 4'h5, 1'b0);
    step(1'b0, 1'b0, 4'h0, 1'b1);
  endtask

`ifdef LED_FRAME_BUFFER_GAMMA_EN
  task automatic test_gamma();
    send_frame(4'hF, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b1);
    check_rows("gamma_f", 32'hFFFF_FFFF);
    send_frame(4'h8, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b1);
    check_rows("gamma_8", 32'h2222_2222);
  endtask
`endif

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_restart();
    test_tick_coincident();
    test_async_reset();
`ifdef LED_FRAME_BUFFER_GAMMA_EN
    test_gamma();
`endif
    idle(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
